sad_trigger_ctrl: RTL and testbench

SAD_TRIGGER_CTRL -- requirements
Module: sad_trigger_ctrl

---
 rtl/sad_trigger_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sad_trigger_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_trigger_ctrl.sv
// sad_trigger_ctrl
//   Qualifies the raw per-cycle SAD match flag into a trigger pulse of
//   pPULSE_WIDTH cycles, optionally followed by a holdoff window. It
//   supports single-shot and re-arming modes and keeps sticky status
//   counters.
//
// Ports
//   clk_adc           : sole clock, rising edge
//   reset             : asynchronous, active-high
//   armed_and_ready   : capture armed (level)
//   match             : raw SAD-below-threshold flag
//   multiple_triggers : 1 = re-arm after each trigger, 0 = single shot
//   holdoff           : cycles match is ignored after a pulse ends
//   status_clear      : one-cycle pulse, zeroes the status outputs
//   trigger           : registered trigger pulse
//   triggered         : sticky "a trigger happened"
//   trigger_count     : saturating count of issued triggers
//   missed_count      : saturating count of match cycles seen in FIRE/HOLDOFF
//   state             : FSM state for debug (IDLE=0 .. DONE=4)
module sad_trigger_ctrl #(
  parameter int pPULSE_WIDTH = 1,
  parameter int pCOUNT_WIDTH = 8
) (
  input  logic                    clk_adc,
  input  logic                    reset,
  input  logic                    armed_and_ready,
  input  logic                    match,
  input  logic                    multiple_triggers,
  input  logic [15:0]             holdoff,
  input  logic                    status_clear,
  output logic                    trigger,
  output logic                    triggered,
  output logic [pCOUNT_WIDTH-1:0] trigger_count,
  output logic [pCOUNT_WIDTH-1:0] missed_count,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_FIRE    = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [3:0]              lpPULSE_LAST = 4'(pPULSE_WIDTH - 1);
  localparam logic [pCOUNT_WIDTH-1:0] lpCNT_MAX    = {pCOUNT_WIDTH{1'b1}};
  localparam logic [pCOUNT_WIDTH-1:0] lpCNT_ONE    = pCOUNT_WIDTH'(1);

  state_t                  r_state, w_state_next;
  logic [3:0]              r_pulse_cnt, w_pulse_cnt_next;
  logic [15:0]             r_hold_cnt, w_hold_cnt_next;
  logic [15:0]             r_hold_lat, w_hold_lat_next;
  logic                    r_abort, w_abort_next;
  logic                    r_trigger;
  logic                    r_triggered, w_triggered_next;
  logic [pCOUNT_WIDTH-1:0] r_trig_cnt, w_trig_cnt_next, w_trig_cnt_base;
  logic [pCOUNT_WIDTH-1:0] r_miss_cnt, w_miss_cnt_next, w_miss_cnt_base;
  logic                    w_fire_entry;
  logic                    w_abort_seen;
  logic                    w_miss;

  // Next-state logic. The pulse counter holds the number of FIRE cycles
  // still to come after the current one, and the holdoff counter does the
  // same for HOLDOFF, so a zero value marks the last cycle of each phase.
  always_comb begin
    w_state_next     = r_state;
    w_pulse_cnt_next = r_pulse_cnt;
    w_hold_cnt_next  = r_hold_cnt;
    w_hold_lat_next  = r_hold_lat;
    w_abort_next     = r_abort;
    w_fire_entry     = 1'b0;
    w_abort_seen     = r_abort | ~armed_and_ready;
    case (r_state)
      ST_IDLE: begin
        if (armed_and_ready) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!armed_and_ready) begin
          w_state_next = ST_IDLE;
        end else if (match) begin
          w_state_next     = ST_FIRE;
          w_pulse_cnt_next = lpPULSE_LAST;
          w_hold_lat_next  = holdoff;
          w_abort_next     = 1'b0;
          w_fire_entry     = 1'b1;
        end
      end
      ST_FIRE: begin
        // A disarm seen at any point of the pulse is remembered; the
        // pulse still runs to completion and then skips holdoff.
        w_abort_next = w_abort_seen;
        if (r_pulse_cnt != 4'd0) begin
          w_pulse_cnt_next = r_pulse_cnt - 4'd1;
        end else if (w_abort_seen) begin
          w_state_next = ST_IDLE;
        end else if (r_hold_lat == 16'd0) begin
          w_state_next = multiple_triggers ? ST_ARMED : ST_DONE;
        end else begin
          w_state_next    = ST_HOLDOFF;
          w_hold_cnt_next = r_hold_lat - 16'd1;
        end
      end
      ST_HOLDOFF: begin
        if (!armed_and_ready) begin
          w_state_next = ST_IDLE;
        end else if (r_hold_cnt == 16'd0) begin
          w_state_next = multiple_triggers ? ST_ARMED : ST_DONE;
        end else begin
          w_hold_cnt_next = r_hold_cnt - 16'd1;
        end
      end
      ST_DONE: begin
        if (!armed_and_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status: the clear is applied first and the increment on top of it,
  // so a coincident clear and event leaves the counter at one.
  always_comb begin
    w_miss          = match & ((r_state == ST_FIRE) | (r_state == ST_HOLDOFF));
    w_trig_cnt_base = status_clear ? '0 : r_trig_cnt;
    w_miss_cnt_base = status_clear ? '0 : r_miss_cnt;
    w_trig_cnt_next = (w_fire_entry && (w_trig_cnt_base != lpCNT_MAX)) ?
                      w_trig_cnt_base + lpCNT_ONE : w_trig_cnt_base;
    w_miss_cnt_next = (w_miss && (w_miss_cnt_base != lpCNT_MAX)) ?
                      w_miss_cnt_base + lpCNT_ONE : w_miss_cnt_base;
    w_triggered_next = w_fire_entry | (r_triggered & ~status_clear);
  end

  always_ff @(posedge clk_adc or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pulse_cnt <= 4'd0;
      r_hold_cnt  <= 16'd0;
      r_hold_lat  <= 16'd0;
      r_abort     <= 1'b0;
      r_trigger   <= 1'b0;
      r_triggered <= 1'b0;
      r_trig_cnt  <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pulse_cnt <= w_pulse_cnt_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_hold_lat  <= w_hold_lat_next;
      r_abort     <= w_abort_next;
      r_trigger   <= (w_state_next == ST_FIRE);
      r_triggered <= w_triggered_next;
      r_trig_cnt  <= w_trig_cnt_next;
      r_miss_cnt  <= w_miss_cnt_next;
    end
  end

  assign trigger       = r_trigger;
  assign triggered     = r_triggered;
  assign trigger_count = r_trig_cnt;
  assign missed_count  = r_miss_cnt;
  assign state         = r_state;

endmodule

// File: tb/tb_sad_trigger_ctrl.sv
// Bench for sad_trigger_ctrl: three instances (pulse widths 1, 2, 4) share
// the same stimulus; each is compared every cycle against a phase-counter
// model of the trigger rules.
module tb_sad_trigger_ctrl;

  localparam int NI = 3;
  localparam int CMAX = 255;
  localparam int PW [NI] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst, arm, mat, mult, clr;
  logic [15:0] hold;

  logic       w_trig [NI];
  logic       w_trd  [NI];
  logic [7:0] w_tc   [NI];
  logic [7:0] w_mc   [NI];
  logic [2:0] w_st   [NI];

  always #5 clk = ~clk;

  sad_trigger_ctrl #(.pPULSE_WIDTH(1), .pCOUNT_WIDTH(8)) u_dut_p1 (
    .clk_adc(clk), .reset(rst), .armed_and_ready(arm), .match(mat),
    .multiple_triggers(mult), .holdoff(hold), .status_clear(clr),
    .trigger(w_trig[0]), .triggered(w_trd[0]), .trigger_count(w_tc[0]),
    .missed_count(w_mc[0]), .state(w_st[0]));
  sad_trigger_ctrl #(.pPULSE_WIDTH(2), .pCOUNT_WIDTH(8)) u_dut_p2 (
    .clk_adc(clk), .reset(rst), .armed_and_ready(arm), .match(mat),
    .multiple_triggers(mult), .holdoff(hold), .status_clear(clr),
    .trigger(w_trig[1]), .triggered(w_trd[1]), .trigger_count(w_tc[1]),
    .missed_count(w_mc[1]), .state(w_st[1]));
  sad_trigger_ctrl #(.pPULSE_WIDTH(4), .pCOUNT_WIDTH(8)) u_dut_p4 (
    .clk_adc(clk), .reset(rst), .armed_and_ready(arm), .match(mat),
    .multiple_triggers(mult), .holdoff(hold), .status_clear(clr),
    .trigger(w_trig[2]), .triggered(w_trd[2]), .trigger_count(w_tc[2]),
    .missed_count(w_mc[2]), .state(w_st[2]));

  // Reference model: remaining pulse cycles, remaining holdoff cycles and
  // two flags (waiting for match, finished) describe the whole behaviour.
  int m_pl [NI], m_hl [NI], m_hlat [NI], m_tc [NI], m_mc [NI];
  bit m_wait [NI], m_done [NI], m_ab [NI], m_trd [NI];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_state(input int k);
    if (m_pl[k] > 0) return 2;
    if (m_hl[k] > 0) return 3;
    if (m_wait[k]) return 1;
    if (m_done[k]) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_pl[k] = 0; m_hl[k] = 0; m_hlat[k] = 0; m_tc[k] = 0; m_mc[k] = 0;
      m_wait[k] = 0; m_done[k] = 0; m_ab[k] = 0; m_trd[k] = 0;
    end
  endtask

  task automatic model_finish(input int k);
    if (mult) m_wait[k] = 1;
    else m_done[k] = 1;
  endtask

  task automatic model_step(input int k);
    bit miss, fire;
    miss = mat && (m_pl[k] > 0 || m_hl[k] > 0);
    fire = 0;
    if (m_pl[k] > 0) begin
      if (!arm) m_ab[k] = 1;
      m_pl[k]--;
      if (m_pl[k] == 0) begin
        if (m_ab[k]) begin m_wait[k] = 0; m_done[k] = 0; end
        else if (m_hlat[k] == 0) model_finish(k);
        else m_hl[k] = m_hlat[k];
      end
    end else if (m_hl[k] > 0) begin
      if (!arm) m_hl[k] = 0;
      else begin
        m_hl[k]--;
        if (m_hl[k] == 0) model_finish(k);
      end
    end else if (m_wait[k]) begin
      if (!arm) m_wait[k] = 0;
      else if (mat) begin
        fire = 1; m_wait[k] = 0; m_pl[k] = PW[k]; m_hlat[k] = int'(hold); m_ab[k] = 0;
      end
    end else if (m_done[k]) begin
      if (!arm) m_done[k] = 0;
    end else if (arm) begin
      m_wait[k] = 1;
    end
    if (clr) begin m_tc[k] = 0; m_mc[k] = 0; m_trd[k] = 0; end
    if (fire) begin
      if (m_tc[k] < CMAX) m_tc[k]++;
      m_trd[k] = 1;
    end
    if (miss && m_mc[k] < CMAX) m_mc[k]++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("trigger[P%0d]", PW[k]), int'(w_trig[k]), (m_pl[k] > 0) ? 1 : 0);
      chk($sformatf("triggered[P%0d]", PW[k]), int'(w_trd[k]), int'(m_trd[k]));
      chk($sformatf("trigger_count[P%0d]", PW[k]), int'(w_tc[k]), m_tc[k]);
      chk($sformatf("missed_count[P%0d]", PW[k]), int'(w_mc[k]), m_mc[k]);
      chk($sformatf("state[P%0d]", PW[k]), int'(w_st[k]), exp_state(k));
    end
  endtask

  // One clock cycle: drive inputs just after an edge, let the next edge
  // sample them, then compare 1 time unit later.
  task automatic cycle(input bit a, input bit m, input bit c);
    arm = a; mat = m; clr = c;
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < NI; k++) model_step(k);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_trigger[P%0d]", tag, PW[k]), int'(w_trig[k]), 0);
      chk($sformatf("%s_triggered[P%0d]", tag, PW[k]), int'(w_trd[k]), 0);
      chk($sformatf("%s_tcount[P%0d]", tag, PW[k]), int'(w_tc[k]), 0);
      chk($sformatf("%s_mcount[P%0d]", tag, PW[k]), int'(w_mc[k]), 0);
      chk($sformatf("%s_state[P%0d]", tag, PW[k]), int'(w_st[k]), 0);
    end
  endtask

  initial begin
    int rises [NI];
    bit prev [NI];
    rst = 1'b1; arm = 1'b0; mat = 1'b0; mult = 1'b0; clr = 1'b0; hold = 16'd0;
    model_reset();
    repeat (3) cycle(1, 1, 0);
    rst = 1'b0;
    $display("reset: outputs idle after reset");

    // Match on the arming cycle is ignored, then single-shot with 3 matches.
    cycle(1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0);
    repeat (5) cycle(1, 0, 0);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("single_tcount[P%0d]", PW[k]), int'(w_tc[k]), 1);
      chk($sformatf("single_state[P%0d]", PW[k]), int'(w_st[k]), 4);
    end
    $display("single: one trigger per arm, parked in DONE");
    repeat (2) cycle(0, 0, 0);

    // Re-arm mode with holdoff=8 and 20 consecutive match cycles.
    mult = 1'b1; hold = 16'd8;
    cycle(1, 0, 1);
    for (int k = 0; k < NI; k++) begin rises[k] = 0; prev[k] = 0; end
    for (int i = 0; i < 36; i++) begin
      cycle(1, (i < 20), 0);
      for (int k = 0; k < NI; k++) begin
        if (w_trig[k] && !prev[k]) rises[k]++;
        prev[k] = w_trig[k];
      end
    end
    for (int k = 0; k < NI; k++)
      chk($sformatf("holdoff_rises[P%0d]", PW[k]), rises[k], 2);
    $display("holdoff: 20 match cycles, two triggers per instance");

    // Saturation of trigger_count, clear, and clear coincident with a trigger.
    hold = 16'd0;
    cycle(1, 0, 1);
    for (int i = 0; i < 300; i++) begin
      cycle(1, 1, 0);
      repeat (5) cycle(1, 0, 0);
    end
    for (int k = 0; k < NI; k++)
      chk($sformatf("sat_tcount[P%0d]", PW[k]), int'(w_tc[k]), 255);
    cycle(1, 0, 1);
    for (int k = 0; k < NI; k++)
      chk($sformatf("clear_tcount[P%0d]", PW[k]), int'(w_tc[k]), 0);
    cycle(1, 1, 1);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("clrfire_tcount[P%0d]", PW[k]), int'(w_tc[k]), 1);
      chk($sformatf("clrfire_triggered[P%0d]", PW[k]), int'(w_trd[k]), 1);
    end
    repeat (6) cycle(1, 0, 0);
    $display("saturation: count held at 255, clear and clear+fire handled");

    // Disarm during the second pulse cycle.
    hold = 16'd3;
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    repeat (6) cycle(0, 1, 0);
    chk("disarm_state[P4]", int'(w_st[2]), 0);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    chk("rearm_trigger[P4]", int'(w_trig[2]), 1);
    repeat (10) cycle(1, 0, 0);
    $display("disarm: pulse completed, match ignored until re-armed");

    // Asynchronous reset with one instance in HOLDOFF and others in FIRE.
    hold = 16'd100;
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    cycle(1, 1, 0);
    rst = 1'b0;
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    for (int k = 0; k < NI; k++)
      chk($sformatf("post_rst_tcount[P%0d]", PW[k]), int'(w_tc[k]), 1);
    $display("async reset: outputs cleared without an edge, re-arm works");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        mult = 1'($urandom_range(0, 1));
        hold = 16'($urandom_range(0, 5));
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 39) == 0));
    end
    rst = 1'b0;
    $display("random: 3000 cycles of mixed traffic");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
